sram_arbiter: RTL

- Two-port arbiter and timing sequencer for the board's external asynchronous 16-bit SRAM (16-bit address, active-low CE/OE/WE/UB/LB, bidirectional data).
- Port 0 is the write/fill engine and port 1 is the display/read path. Each port issues single-word requests over a req/gnt/done handshake.
- The block owns every SRAM pin and the data tri-state. It enforces setup, access and hold timing so that requesters never drive the SRAM directly.

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 33 +++
 rtl/sram_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, width defaults and counter sizing for the external SRAM arbiter.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } sram_state_t;

    localparam int SRAM_ADDR_W = 16;
    localparam int SRAM_DATA_W = 16;

    // The ACCESS counter only has to hold ACC_CYCLES-1.
    function automatic int acc_cnt_w(input int acc_cycles);
        return (acc_cycles <= 2) ? 1 : $clog2(acc_cycles);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the port that was not granted last wins.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_last_gnt;

    always_comb begin
        o_grant = 2'b00;
        if (i_req0 && i_req1) begin
            o_grant = r_last_gnt ? 2'b01 : 2'b10;
        end else if (i_req0) begin
            o_grant = 2'b01;
        end else if (i_req1) begin
            o_grant = 2'b10;
        end
    end

    // Reset to port 1 so that port 0 wins the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_gnt <= 1'b1;
        end else if (i_advance && (o_grant != 2'b00)) begin
            r_last_gnt <= o_grant[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and timing sequencer for an asynchronous SRAM; owns every SRAM pin
// and the data tri-state, running IDLE -> SETUP -> ACCESS -> HOLD per access.
module sram_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int ACC_CYCLES = 2
) (
    input  logic              sys_clk_in,
    input  logic              rst_in,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        be0,
    input  logic [1:0]        be1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    inout  wire  [DATA_W-1:0] sram_data
);

    localparam int CNT_W = acc_cnt_w(ACC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYCLES - 1);

    generate
        if (ACC_CYCLES < 1 || ACC_CYCLES > 15) begin : g_bad_acc
            $error("sram_arbiter: ACC_CYCLES must lie within 1..15");
        end
    endgenerate

    sram_state_t       r_state;
    sram_state_t       w_nx_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        w_grant;
    logic              w_advance;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [1:0]        w_sel_be;
    logic              r_port;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_drive;
    logic [ADDR_W-1:0] r_sram_addr;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_ub_n;
    logic              r_lb_n;
    logic              r_done0;
    logic              r_done1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    rr_arbiter2 u_rr (
        .i_clk     (sys_clk_in),
        .i_rst     (rst_in),
        .i_req0    (req0),
        .i_req1    (req1),
        .i_advance (w_advance),
        .o_grant   (w_grant)
    );

    assign w_sel_we    = w_grant[1] ? we1    : we0;
    assign w_sel_addr  = w_grant[1] ? addr1  : addr0;
    assign w_sel_wdata = w_grant[1] ? wdata1 : wdata0;
    assign w_sel_be    = w_grant[1] ? be1    : be0;

    always_comb begin
        w_nx_state = r_state;
        w_advance  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant != 2'b00) begin
                    w_nx_state = SETUP;
                    w_advance  = 1'b1;
                end
            end
            SETUP:   w_nx_state = ACCESS;
            ACCESS:  if (r_cnt == '0) w_nx_state = HOLD;
            HOLD:    w_nx_state = IDLE;
            default: w_nx_state = IDLE;
        endcase
    end

    // Grant is combinational so the requester's fields are latched in the very cycle gnt is seen.
    assign gnt0 = w_advance & w_grant[0] & ~rst_in;
    assign gnt1 = w_advance & w_grant[1] & ~rst_in;
    assign busy = (r_state != IDLE);

    // SRAM pins are registered from the next state so each pin is stable for the whole state.
    always_ff @(posedge sys_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_port      <= 1'b0;
            r_we        <= 1'b0;
            r_sram_addr <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_drive     <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
        end else begin
            r_state <= w_nx_state;
            if (r_state == SETUP) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == ACCESS && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_advance) begin
                r_port      <= w_grant[1];
                r_we        <= w_sel_we;
                r_sram_addr <= w_sel_addr;
                r_ub_n      <= ~w_sel_be[1];
                r_lb_n      <= ~w_sel_be[0];
            end else if (w_nx_state == IDLE) begin
                r_ub_n <= 1'b1;
                r_lb_n <= 1'b1;
            end
            r_ce_n  <= (w_nx_state == IDLE);
            r_we_n  <= !(w_nx_state == ACCESS && r_we);
            r_oe_n  <= !(w_nx_state == ACCESS && !r_we);
            r_drive <= (w_nx_state == ACCESS || w_nx_state == HOLD) && r_we;
            r_done0 <= (w_nx_state == HOLD) && !r_port;
            r_done1 <= (w_nx_state == HOLD) && r_port;
        end
    end

    always_ff @(posedge sys_clk_in) begin
        if (w_advance) begin
            r_wdata <= w_sel_wdata;
        end
    end

    // Read data is captured at the end of the last ACCESS cycle, ready alongside done.
    always_ff @(posedge sys_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == ACCESS && r_cnt == '0 && !r_we) begin
            if (r_port) begin
                r_rdata1 <= sram_data;
            end else begin
                r_rdata0 <= sram_data;
            end
        end
    end

    assign sram_data = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign sram_addr = r_sram_addr;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_ub_n = r_ub_n;
    assign sram_lb_n = r_lb_n;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;

endmodule
